// File: rtl/pos_sweep_checker.sv
// Sweep driver/checker for the 4-input PoS stage: walks {X,Y,W,Z} 0..15, compares S1 vs S2.
// Optional build macro STOP_ON_MISMATCH_EN ends the sweep at the first mismatching vector.
module pos_sweep_checker #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        S1,
  input  logic        S2,
  output logic        X,
  output logic        Y,
  output logic        W,
  output logic        Z,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  mism_cnt,
  output logic [3:0]  first_bad,
  output logic        first_valid,
  output logic [15:0] s1_map,
  output logic [15:0] s2_map
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [4:0]  mism_q, mism_d;
  logic [3:0]  fbad_q, fbad_d;
  logic        fvld_q, fvld_d;
  logic [15:0] s1map_q, s1map_d;
  logic [15:0] s2map_q, s2map_d;
  logic        pass_q, pass_d;
  logic        miss;

  assign miss = S1 ^ S2;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      mism_q  <= '0;
      fbad_q  <= '0;
      fvld_q  <= 1'b0;
      s1map_q <= '0;
      s2map_q <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      mism_q  <= mism_d;
      fbad_q  <= fbad_d;
      fvld_q  <= fvld_d;
      s1map_q <= s1map_d;
      s2map_q <= s2map_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    mism_d  = mism_q;
    fbad_d  = fbad_q;
    fvld_d  = fvld_q;
    s1map_d = s1map_q;
    s2map_d = s2map_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DRIVE;
          idx_d   = '0;
          cnt_d   = '0;
          mism_d  = '0;
          fbad_d  = '0;
          fvld_d  = 1'b0;
          s1map_d = '0;
          s2map_d = '0;
          pass_d  = 1'b0;
        end
      end
      DRIVE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == SETTLE_LAST) state_d = SAMPLE;
      end
      SAMPLE: begin
        s1map_d[idx_q] = S1;
        s2map_d[idx_q] = S2;
        if (miss) begin
          mism_d = mism_q + 5'd1;
          if (!fvld_q) begin
            fbad_d = idx_q;
            fvld_d = 1'b1;
          end
        end
`ifdef STOP_ON_MISMATCH_EN
        if (miss || idx_q == 4'd15) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 4'd1;
          cnt_d   = '0;
          state_d = DRIVE;
        end
`else
        if (idx_q == 4'd15) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 4'd1;
          cnt_d   = '0;
          state_d = DRIVE;
        end
`endif
      end
      DONE: begin
        // mism_q already includes the last vector's SAMPLE update here
        pass_d  = (mism_q == 5'd0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign {X, Y, W, Z} = idx_q;
  assign busy         = (state_q == DRIVE) || (state_q == SAMPLE);
  assign done         = (state_q == DONE);
  assign pass         = pass_q;
  assign mism_cnt     = mism_q;
  assign first_bad    = fbad_q;
  assign first_valid  = fvld_q;
  assign s1_map       = s1map_q;
  assign s2_map       = s2map_q;

endmodule

// File: tb/tb_pos_sweep_checker.sv
// Directed bench for pos_sweep_checker: PoS stage model is 0 only at vectors 2,5,7,10.
module tb_pos_sweep_checker;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, start3 = 1'b0, s2_force = 1'b0;
  logic S1, S2, X, Y, W, Z, busy, done, pass, first_valid;
  logic [4:0] mism_cnt;
  logic [3:0] first_bad;
  logic [15:0] s1_map, s2_map;
  logic S1b, S2b, Xb, Yb, Wb, Zb, busyb, doneb, passb, fvb;
  logic [4:0] mismb;
  logic [3:0] fbb;
  logic [15:0] s1b_map, s2b_map;
  int total = 0, bad = 0;
  int dc, verr, n;

  always #5 clk = ~clk;

  function automatic logic pos_f(input logic [3:0] v);
    return !(v == 4'd2 || v == 4'd5 || v == 4'd7 || v == 4'd10);
  endfunction

  assign S1  = pos_f({X, Y, W, Z});
  assign S2  = s2_force ? 1'b1 : S1;
  assign S1b = pos_f({Xb, Yb, Wb, Zb});
  assign S2b = S1b;

  pos_sweep_checker #(.SETTLE(1)) u_dut (
    .clk(clk), .reset(reset), .start(start), .S1(S1), .S2(S2),
    .X(X), .Y(Y), .W(W), .Z(Z), .busy(busy), .done(done), .pass(pass),
    .mism_cnt(mism_cnt), .first_bad(first_bad), .first_valid(first_valid),
    .s1_map(s1_map), .s2_map(s2_map));

  pos_sweep_checker #(.SETTLE(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3), .S1(S1b), .S2(S2b),
    .X(Xb), .Y(Yb), .W(Wb), .Z(Zb), .busy(busyb), .done(doneb), .pass(passb),
    .mism_cnt(mismb), .first_bad(fbb), .first_valid(fvb),
    .s1_map(s1b_map), .s2_map(s2b_map));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Returns the cycle (counted from the start edge) in which done is seen; 0 on timeout.
  task automatic sweep1(input bit pulse, input int repulse_at, output int done_cyc, output int vec_err);
    done_cyc = 0;
    vec_err  = 0;
    if (pulse) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    for (int cyc = 1; cyc <= 200; cyc++) begin
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (busy && {X, Y, W, Z} != 4'((cyc - 1) / 2)) vec_err++;
      start = (cyc == repulse_at);
      tick();
    end
    start = 1'b0;
  endtask

  task automatic chk_results(input string p, input logic [15:0] e1, input logic [15:0] e2,
                             input logic [4:0] em, input logic [3:0] eb, input logic ev,
                             input logic ep, input logic [3:0] evec);
    chk({p, "_s1map"}, s1_map, e1);
    chk({p, "_s2map"}, s2_map, e2);
    chk({p, "_mism"}, mism_cnt, em);
    chk({p, "_fbad"}, first_bad, eb);
    chk({p, "_fvld"}, first_valid, ev);
    chk({p, "_pass"}, pass, ep);
    chk({p, "_vec"}, {X, Y, W, Z}, evec);
  endtask

  initial begin
    // reset state
    tick(); tick();
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk_results("rst", 16'h0, 16'h0, 5'd0, 4'd0, 1'b0, 1'b0, 4'd0);

    // clean sweep, SETTLE=1
    s2_force = 1'b0;
    sweep1(1'b1, 0, dc, verr);
    chk("s2_done_cyc", dc, 33);
    chk("s2_vec_order", verr, 0);
    tick();
    chk("s2_done_pulse", done, 0);
    chk_results("s2", 16'hFB5B, 16'hFB5B, 5'd0, 4'd0, 1'b0, 1'b1, 4'hF);

    // S2 stuck at 1
    s2_force = 1'b1;
    sweep1(1'b1, 0, dc, verr);
`ifdef STOP_ON_MISMATCH_EN
    chk("s5_done_cyc", dc, 7);
    tick();
    chk_results("s5", 16'h0003, 16'h0007, 5'd1, 4'd2, 1'b1, 1'b0, 4'd2);
`else
    chk("s3_done_cyc", dc, 33);
    tick();
    chk_results("s3", 16'hFB5B, 16'hFFFF, 5'd4, 4'd2, 1'b1, 1'b0, 4'hF);
`endif

    // start re-pulsed mid-sweep is ignored
    s2_force = 1'b0;
    sweep1(1'b1, 10, dc, verr);
    chk("s4_repulse_done_cyc", dc, 33);
    chk("s4_vec_order", verr, 0);
    tick();
    chk("s4_idle_after", busy, 0);

    // SETTLE=3 instance
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    dc = 0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      if (doneb) begin
        dc = cyc;
        break;
      end
      tick();
    end
    chk("s4_settle3_done_cyc", dc, 65);
    tick();
    chk("s4_settle3_s1map", s1b_map, 16'hFB5B);
    chk("s4_settle3_pass", passb, 1);

    // reset mid-sweep at idx=6 (and start during reset loses)
`ifdef STOP_ON_MISMATCH_EN
    s2_force = 1'b0;
`else
    s2_force = 1'b1;
`endif
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while ({X, Y, W, Z} != 4'd6 && n < 100) begin
      tick();
      n++;
    end
    chk("r_reach_idx6", {X, Y, W, Z}, 4'd6);
    reset = 1'b1;
    tick();
    chk("r_busy", busy, 0);
    chk("r_done", done, 0);
    chk_results("r", 16'h0, 16'h0, 5'd0, 4'd0, 1'b0, 1'b0, 4'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    reset = 1'b0;
    chk("r_start_vs_reset", busy, 0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) n++;
      tick();
    end
    chk("r_no_done_after", n, 0);

    // back-to-back sweeps with start held high
    s2_force = 1'b1;
    start = 1'b1;
    tick();
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    chk("b2b_first_done", done, 1);
    tick();
    chk("b2b_idle_busy", busy, 0);
    chk("b2b_idle_pass", pass, 0);
    tick();
    start = 1'b0;
    s2_force = 1'b0;
    chk("b2b_restart_busy", busy, 1);
    chk("b2b_clr_mism", mism_cnt, 0);
    chk("b2b_clr_fvld", first_valid, 0);
    chk("b2b_clr_s2map", s2_map, 16'h0);
    sweep1(1'b0, 0, dc, verr);
    chk("b2b_done_cyc", dc, 33);
    chk("b2b_vec_order", verr, 0);
    tick();
    chk_results("b2b", 16'hFB5B, 16'hFB5B, 5'd0, 4'd0, 1'b0, 1'b1, 4'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
